keypad_entry: RTL and testbench
===============================

KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 The module SHALL have parameter DEBOUNCE, default 4: the number of consecutive clk cycles a synchronized key level must hold before it is accepted (legal range 2..255).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock, with all logic on the rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port value, input, 16 bits: keypad key code, where value[3:0] is the key (0..F) and value[15:4] is ignored.
REQ-005 The module SHALL have port valid, input, 1 bit: key-held level from the keypad stage, asynchronous to clk.
REQ-006 The module SHALL have port op_ready, input, 1 bit: consumer accepts the operand.
REQ-007 The module SHALL have port op_valid, output, 1 bit: committed operand available.
REQ-008 The module SHALL have port operand, output, 16 bits: committed 4-digit BCD, with the most recently entered digit in the LSB nibble.
REQ-009 The module SHALL have port op_sign, output, 1 bit: committed sign, 1 meaning negative.
REQ-010 The module SHALL have port entry, output, 16 bits: live BCD edit buffer for display.
REQ-011 The module SHALL have port entry_sign, output, 1 bit: live sign.
REQ-012 The module SHALL have port digit_count, output, 3 bits: number of digits in the buffer (0..4).
REQ-013 The module SHALL have port key_event, output, 1 bit: one-cycle pulse per accepted press.

Function
REQ-014 The module SHALL synchronize valid and value[3:0] through a 2-flop synchronizer before any other use.
REQ-015 The module SHALL use a press FSM with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-016 IDLE SHALL go to PRESS_WAIT when sync valid=1, loading the count and the code.
REQ-017 PRESS_WAIT SHALL return to IDLE if sync valid=0 or the code changes, and SHALL go to HELD after DEBOUNCE consecutive stable cycles, asserting key_event for exactly that transition cycle.
REQ-018 HELD SHALL go to RELEASE_WAIT when sync valid=0.
REQ-019 RELEASE_WAIT SHALL return to HELD if valid reasserts, and SHALL go to IDLE after DEBOUNCE consecutive low cycles.
REQ-020 A held key SHALL produce exactly one key_event, with no auto-repeat.
REQ-021 The buffer SHALL update on the clk edge following key_event.
REQ-022 Keys 0-9 (digits): if digit_count<4, entry SHALL become {entry[11:0], key} and digit_count SHALL increment; if digit_count=4, the press SHALL be ignored.
REQ-023 Key B (backspace): if digit_count>0, entry SHALL become {4'h0, entry[15:4]} and digit_count SHALL decrement; if digit_count=0, the press SHALL be a no-op.
REQ-024 Key C (clear) SHALL set entry=0, digit_count=0 and entry_sign=0.
REQ-025 Key D (negate) SHALL toggle entry_sign, including when digit_count=0.
REQ-026 Key A (enter): if digit_count>0 and op_valid=0, the module SHALL load operand=entry and op_sign=entry_sign, set op_valid=1, and clear the buffer to 0, count 0 and sign 0, all in the same edge.
REQ-027 Key A SHALL be ignored if digit_count=0 or op_valid=1.
REQ-028 Keys E and F SHALL assert key_event and have no other effect.
REQ-029 Handshake: a transfer SHALL occur on a cycle with op_valid=1 and op_ready=1; op_valid SHALL be 0 the next cycle; operand and op_sign SHALL stay stable while op_valid=1.
REQ-030 op_ready while op_valid=0 SHALL have no effect.
REQ-031 Digit, backspace, clear and negate SHALL still edit the buffer while op_valid=1; the pending operand SHALL be unaffected.
REQ-032 Latency from valid rising (stable) to the entry update SHALL be 2 (sync) + DEBOUNCE + 1 clk cycles.

Reset
REQ-033 On reset=1 at a clk edge, the FSM SHALL go to IDLE, and the counters, synchronizers, entry, entry_sign, digit_count, operand, op_sign, op_valid and key_event SHALL all be 0.
REQ-034 Reset SHALL take priority over every other event, and any pending operand SHALL be dropped.
REQ-035 A key held through reset release SHALL be accepted only after a full DEBOUNCE qualification from IDLE.

Configuration
REQ-036 With macro KEYPAD_ENTRY_OVERFLOW_EN defined, the module SHALL add output overflow (1 bit, reset 0), set sticky on a digit press at digit_count=4 and cleared by key C, by a successful key A, or by reset.
REQ-037 Without KEYPAD_ENTRY_OVERFLOW_EN, the port and its logic SHALL be absent, and overflowing digits SHALL be silently ignored.

Verification
REQ-038 DEBOUNCE=4: press 7 with valid held 20 cycles, then release -> exactly one key_event; entry=16'h0007; digit_count=1.
REQ-039 Press 1,2,3,4,5 -> entry=16'h1234, digit_count=4; with the macro, overflow=1.
REQ-040 Entry 16'h1234, then press B, B -> entry=16'h0012, digit_count=2; press C -> entry=0, digit_count=0.
REQ-041 Press 4, 2, D, A with op_ready=0 -> op_valid=1, operand=16'h0042, op_sign=1, entry=0; a second entry of 9 followed by A is ignored; op_ready=1 for one cycle -> op_valid=0 the next cycle.
REQ-042 valid toggling every 2 cycles for 30 cycles -> no key_event; reset asserted while in HELD with op_valid=1 -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - debounced keypad to signed 4-digit BCD operand entry with ready/valid output
// Optional sticky overflow flag when KEYPAD_ENTRY_OVERFLOW_EN is defined.
module keypad_entry #(
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        valid,
  input  logic        op_ready,
  output logic        op_valid,
  output logic [15:0] operand,
  output logic        op_sign,
  output logic [15:0] entry,
  output logic        entry_sign,
  output logic [2:0]  digit_count,
  output logic        key_event
`ifdef KEYPAD_ENTRY_OVERFLOW_EN
  ,
  output logic        overflow
`endif
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  localparam logic [7:0] DB = 8'(DEBOUNCE);

  state_t      state, state_next;
  logic [7:0]  count, count_next;
  logic [3:0]  code, code_next;
  logic        valid_s1, valid_s2;
  logic [3:0]  code_s1, code_s2;
  logic        unused_value_bits;

  assign unused_value_bits = ^value[15:4];

  // valid is asynchronous; the code is sampled alongside it so both age identically
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_s1 <= 1'b0;
      valid_s2 <= 1'b0;
      code_s1  <= 4'h0;
      code_s2  <= 4'h0;
    end else begin
      valid_s1 <= valid;
      valid_s2 <= valid_s1;
      code_s1  <= value[3:0];
      code_s2  <= code_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= 8'd0;
      code  <= 4'h0;
    end else begin
      state <= state_next;
      count <= count_next;
      code  <= code_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    code_next  = code;
    key_event  = 1'b0;
    case (state)
      IDLE: begin
        if (valid_s2) begin
          state_next = PRESS_WAIT;
          count_next = 8'd1;
          code_next  = code_s2;
        end
      end
      PRESS_WAIT: begin
        if (!valid_s2 || (code_s2 != code)) begin
          state_next = IDLE;
        end else if (count == DB) begin
          state_next = HELD;
          key_event  = 1'b1;
        end else begin
          count_next = count + 8'd1;
        end
      end
      HELD: begin
        if (!valid_s2) begin
          state_next = RELEASE_WAIT;
          count_next = 8'd1;
        end
      end
      RELEASE_WAIT: begin
        if (valid_s2) begin
          state_next = HELD;
        end else if (count == DB) begin
          state_next = IDLE;
        end else begin
          count_next = count + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entry       <= 16'h0;
      entry_sign  <= 1'b0;
      digit_count <= 3'd0;
      operand     <= 16'h0;
      op_sign     <= 1'b0;
      op_valid    <= 1'b0;
    end else begin
      if (op_valid && op_ready) begin
        op_valid <= 1'b0;
      end
      if (key_event) begin
        case (code)
          4'hA: begin
            // enter only commits when the previous operand has been consumed
            if (digit_count != 3'd0 && !op_valid) begin
              operand     <= entry;
              op_sign     <= entry_sign;
              op_valid    <= 1'b1;
              entry       <= 16'h0;
              entry_sign  <= 1'b0;
              digit_count <= 3'd0;
            end
          end
          4'hB: begin
            if (digit_count != 3'd0) begin
              entry       <= {4'h0, entry[15:4]};
              digit_count <= digit_count - 3'd1;
            end
          end
          4'hC: begin
            entry       <= 16'h0;
            entry_sign  <= 1'b0;
            digit_count <= 3'd0;
          end
          4'hD: entry_sign <= ~entry_sign;
          4'hE, 4'hF: ;
          default: begin
            if (digit_count < 3'd4) begin
              entry       <= {entry[11:0], code};
              digit_count <= digit_count + 3'd1;
            end
          end
        endcase
      end
    end
  end

`ifdef KEYPAD_ENTRY_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (key_event) begin
      if (code <= 4'h9 && digit_count == 3'd4) begin
        overflow <= 1'b1;
      end else if (code == 4'hC) begin
        overflow <= 1'b0;
      end else if (code == 4'hA && digit_count != 3'd0 && !op_valid) begin
        overflow <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - self-checking bench for keypad_entry against a digit-queue model
module tb_keypad_entry;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        valid;
  logic        op_ready;
  logic        op_valid;
  logic [15:0] operand;
  logic        op_sign;
  logic [15:0] entry;
  logic        entry_sign;
  logic [2:0]  digit_count;
  logic        key_event;
`ifdef KEYPAD_ENTRY_OVERFLOW_EN
  logic        overflow;
`endif

  keypad_entry #(.DEBOUNCE(D)) dut (
    .clk(clk), .reset(reset), .value(value), .valid(valid), .op_ready(op_ready),
    .op_valid(op_valid), .operand(operand), .op_sign(op_sign), .entry(entry),
    .entry_sign(entry_sign), .digit_count(digit_count), .key_event(key_event)
`ifdef KEYPAD_ENTRY_OVERFLOW_EN
    , .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int errors = 0;
  int checks = 0;
  int ke_count = 0;
  bit check_en = 0;

  // model: digits oldest-first, a press is expected D+2 cycles after valid rises
  int          m_digits[$];
  bit          m_sign, m_opv, m_ops, m_ovf;
  logic [15:0] m_opd;
  int          ev_cyc[$];
  logic [3:0]  ev_key[$];

  function automatic logic [15:0] model_entry();
    logic [15:0] e = 16'h0;
    foreach (m_digits[i]) e = (e << 4) | 16'(m_digits[i]);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic apply_key(input logic [3:0] k, input bit opv_now);
    if (k <= 4'h9) begin
      if (m_digits.size() < 4) m_digits.push_back(int'(k));
      else m_ovf = 1;
    end else if (k == 4'hA) begin
      if (m_digits.size() > 0 && !opv_now) begin
        m_opd = model_entry(); m_ops = m_sign; m_opv = 1;
        m_digits.delete(); m_sign = 0; m_ovf = 0;
      end
    end else if (k == 4'hB) begin
      if (m_digits.size() > 0) void'(m_digits.pop_back());
    end else if (k == 4'hC) begin
      m_digits.delete(); m_sign = 0; m_ovf = 0;
    end else if (k == 4'hD) begin
      m_sign = ~m_sign;
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      bit exp_ke;
      bit opv_now;
      exp_ke = (ev_cyc.size() > 0) && (ev_cyc[0] == cyc);
      if (key_event === 1'b1) ke_count++;
      check("key_event", 32'(key_event), 32'(exp_ke));
      check("entry", 32'(entry), 32'(model_entry()));
      check("entry_sign", 32'(entry_sign), 32'(m_sign));
      check("digit_count", 32'(digit_count), 32'(m_digits.size()));
      check("op_valid", 32'(op_valid), 32'(m_opv));
      if (m_opv) begin
        check("operand", 32'(operand), 32'(m_opd));
        check("op_sign", 32'(op_sign), 32'(m_ops));
      end
`ifdef KEYPAD_ENTRY_OVERFLOW_EN
      check("overflow", 32'(overflow), 32'(m_ovf));
`endif
      if (reset) begin
        m_digits.delete(); m_sign = 0; m_opv = 0; m_ops = 0; m_opd = 16'h0; m_ovf = 0;
        ev_cyc.delete(); ev_key.delete();
      end else begin
        opv_now = m_opv;
        if (m_opv && op_ready) m_opv = 0;
        if (exp_ke) begin
          void'(ev_cyc.pop_front());
          apply_key(ev_key.pop_front(), opv_now);
        end
      end
    end
  end

  task automatic start_key(input logic [3:0] k);
    @(posedge clk); #1;
    valid = 1'b1;
    value = {12'hA5C, k};
    ev_cyc.push_back(cyc + D + 2);
    ev_key.push_back(k);
  endtask

  task automatic release_key();
    valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k, input int hold);
    start_key(k);
    repeat (hold) @(posedge clk);
    #1;
    release_key();
  endtask

  initial begin
    int ke_before;
    reset = 1'b1; valid = 1'b0; value = 16'h0; op_ready = 1'b0;
    m_opd = 16'h0;
    @(posedge clk); #1;
    check_en = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_entry", 32'(entry), 32'h0);
    check("reset_op_valid", 32'(op_valid), 32'h0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    press(4'h7, 20);
    check("single_event", 32'(ke_count), 32'd1);
    check("lit_entry_7", 32'(entry), 32'h0007);
    check("lit_count_1", 32'(digit_count), 32'd1);

    press(4'hC, D + 4);
    press(4'h1, D + 4); press(4'h2, D + 4); press(4'h3, D + 4);
    press(4'h4, D + 4); press(4'h5, D + 4);
    check("lit_entry_1234", 32'(entry), 32'h1234);
    check("lit_count_4", 32'(digit_count), 32'd4);
`ifdef KEYPAD_ENTRY_OVERFLOW_EN
    check("lit_overflow", 32'(overflow), 32'd1);
`endif

    press(4'hB, D + 4); press(4'hB, D + 4);
    check("lit_entry_0012", 32'(entry), 32'h0012);
    check("lit_count_2", 32'(digit_count), 32'd2);
    press(4'hC, D + 4);
    check("lit_clear", 32'({digit_count, entry}), 32'h0);

    press(4'hB, D + 4);
    press(4'hD, D + 4);
    check("lit_neg_empty", 32'(entry_sign), 32'd1);
    press(4'hD, D + 4);
    press(4'hE, D + 4);
    press(4'hA, D + 4);
    check("lit_enter_empty", 32'(op_valid), 32'd0);

    op_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 op_ready = 1'b0;

    press(4'h4, D + 4); press(4'h2, D + 4); press(4'hD, D + 4); press(4'hA, D + 4);
    check("lit_op_valid", 32'(op_valid), 32'd1);
    check("lit_operand_0042", 32'(operand), 32'h0042);
    check("lit_op_sign", 32'(op_sign), 32'd1);
    check("lit_entry_after_a", 32'(entry), 32'h0);
    press(4'h9, D + 4); press(4'hA, D + 4);
    check("lit_operand_held", 32'(operand), 32'h0042);
    check("lit_entry_0009", 32'(entry), 32'h0009);
    @(posedge clk); #1 op_ready = 1'b1;
    @(posedge clk); #1 op_ready = 1'b0;
    check("lit_op_valid_drop", 32'(op_valid), 32'd0);

    ke_before = ke_count;
    value = 16'h0003;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      valid = ((i / 2) % 2 == 0);
    end
    release_key();
    check("lit_bounce_no_event", 32'(ke_count), 32'(ke_before));

    press(4'hA, D + 4);
    check("lit_op_valid_9", 32'(op_valid), 32'd1);
    start_key(4'h5);
    repeat (D + 6) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("lit_reset_all_zero",
          32'({op_valid, operand, entry_sign, digit_count, key_event, op_sign}), 32'h0);
    check("lit_reset_entry", 32'(entry), 32'h0);
    reset = 1'b0;
    ev_cyc.push_back(cyc + D + 2);
    ev_key.push_back(4'h5);
    repeat (D + 6) @(posedge clk);
    #1;
    release_key();
    check("lit_requal_entry_5", 32'(entry), 32'h0005);
    check("lit_dropped_operand", 32'(op_valid), 32'd0);
    check("events_drained", 32'(ev_cyc.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
